// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared types and constants for the memory-mapped UART transmitter
package mmio_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int status_busy  = 0;
   localparam int status_empty = 1;
   localparam int status_full  = 2;
   localparam int status_ovf   = 3;
   localparam int status_par   = 4;

   localparam logic [31:0] DEFAULT_TX_ADDR     = 32'hFFFF_0000;
   localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'hFFFF_0004;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-stage snoop bus and serial outputs of the UART transmitter
interface mmio_uart_tx_if;
   logic        is_data_stage;
   logic        store_en;
   logic        load_en;
   logic [31:0] long_addr;
   logic [31:0] write_value;
   logic        hit;
   logic [31:0] read_value;
   logic        tx;
   logic        busy;

   modport master (
      output is_data_stage, store_en, load_en, long_addr, write_value,
      input  hit, read_value, tx, busy
   );

   modport slave (
      input  is_data_stage, store_en, load_en, long_addr, write_value,
      output hit, read_value, tx, busy
   );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - single-clock FIFO holding bytes waiting for the serializer
module sync_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with status register; UART_PARITY_EN adds an even-parity bit
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] TX_ADDR     = DEFAULT_TX_ADDR,
   parameter logic [31:0] STATUS_ADDR = DEFAULT_STATUS_ADDR,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          BAUD_DIV    = 16
) (
   input  logic          clock,
   input  logic          reset,
   mmio_uart_tx_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'(IDLE);
   localparam logic [2:0] S_START  = 3'(START);
   localparam logic [2:0] S_DATA   = 3'(DATA);
   localparam logic [2:0] S_PARITY = 3'(PARITY);
   localparam logic [2:0] S_STOP   = 3'(STOP);

   localparam int            BW        = $clog2(BAUD_DIV);
   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef UART_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
   logic par_q, par_d;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   logic          acc, push_req, status_rd, drop;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          unused_bits;

   logic [2:0]    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          overflow_q, overflow_d;
   logic          hit_q, hit_d;
   logic [31:0]   read_q, read_d;
   logic          busy, baud_last;
   logic [31:0]   status_word;

   assign acc       = bus.is_data_stage & (bus.store_en | bus.load_en);
   assign push_req  = acc & bus.store_en & (bus.long_addr == TX_ADDR);
   assign status_rd = acc & bus.load_en & (bus.long_addr == STATUS_ADDR);
   assign drop      = push_req & fifo_full & ~fifo_pop;
   assign busy      = (state_q != S_IDLE) | ~fifo_empty;
   assign baud_last = (baud_q == BAUD_LAST);

   assign unused_bits = ^{bus.write_value[31:8], fifo_count};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .push_i  (push_req),
      .wdata_i (bus.write_value[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      status_word               = '0;
      status_word[status_busy]  = busy;
      status_word[status_empty] = fifo_empty;
      status_word[status_full]  = fifo_full;
      status_word[status_ovf]   = overflow_q;
      status_word[status_par]   = PAR_FLAG;
   end

   // A dropped push wins over the clear-on-read so no overflow is lost.
   assign overflow_d = drop ? 1'b1 : (status_rd ? 1'b0 : overflow_q);
   assign hit_d      = acc ? status_rd : hit_q;
   assign read_d     = status_rd ? status_word : read_q;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) fifo_pop = 1'b1;
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               baud_d  = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = par_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               state_d = S_STOP;
               baud_d  = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Frame start is shared by IDLE and the back-to-back path out of STOP.
      if (fifo_pop) begin
         state_d = S_START;
         shift_d = fifo_rdata;
         baud_d  = '0;
         tx_d    = 1'b0;
`ifdef UART_PARITY_EN
         par_d   = ^fifo_rdata;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
         hit_q      <= 1'b0;
         read_q     <= '0;
`ifdef UART_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
         hit_q      <= hit_d;
         read_q     <= read_d;
`ifdef UART_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign bus.hit        = hit_q;
   assign bus.read_value = read_q;
   assign bus.tx         = tx_q;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with a frame-decoding scoreboard
module tb_mmio_uart_tx;
   localparam int BAUD = 4;
`ifdef UART_PARITY_EN
   localparam int          FRAME_BITS = 11;
   localparam logic [31:0] PAR_FLAG   = 32'h10;
`else
   localparam int          FRAME_BITS = 10;
   localparam logic [31:0] PAR_FLAG   = 32'h0;
`endif
   localparam int          FRAME_CYC = FRAME_BITS * BAUD;
   localparam logic [31:0] TXA       = 32'hFFFF_0000;
   localparam logic [31:0] STA       = 32'hFFFF_0004;
   localparam logic [31:0] ST_IDLE   = 32'h2 | PAR_FLAG;

   logic clock = 1'b0;
   logic reset = 1'b1;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .TX_ADDR(TXA), .STATUS_ADDR(STA), .FIFO_DEPTH(4), .BAUD_DIV(BAUD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame decoder: samples each bit mid-period and pops the scoreboard at the stop bit.
   bit         mon_active = 1'b0;
   int         mon_cnt    = 0;
   int         mon_k      = 0;
   logic [7:0] mon_byte   = '0;

   always @(negedge clock) begin
      if (reset) begin
         mon_active = 1'b0;
      end else begin
         if (mon_active) mon_cnt++;
         else if (bus.tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_byte   = '0;
         end
         if (mon_active && (mon_cnt % BAUD) == BAUD / 2) begin
            mon_k = mon_cnt / BAUD;
            if (mon_k == 0) check("start_bit", 32'(bus.tx), 32'h0);
            else if (mon_k <= 8) mon_byte = {bus.tx, mon_byte[7:1]};
`ifdef UART_PARITY_EN
            else if (mon_k == 9) check("parity_bit", 32'(bus.tx), 32'(^mon_byte));
`endif
            else begin
               check("stop_bit", 32'(bus.tx), 32'h1);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_frame: got byte 0x%0h expected no frame", mon_byte);
               end else begin
                  check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
               end
            end
         end
         if (mon_active && mon_cnt == FRAME_CYC - 1) mon_active = 1'b0;
      end
   end

   task automatic bus_op(input logic ds, input logic st, input logic ld,
                         input logic [31:0] addr, input logic [31:0] data);
      bus.is_data_stage = ds;
      bus.store_en      = st;
      bus.load_en       = ld;
      bus.long_addr     = addr;
      bus.write_value   = data;
      @(negedge clock);
      bus.is_data_stage = 1'b0;
      bus.store_en      = 1'b0;
      bus.load_en       = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (bus.busy && cyc < limit);
      if (bus.busy) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_idle_timeout: got busy=1 after %0d cycles expected 0", cyc);
      end
   endtask

   typedef struct {
      logic        ds;
      logic        st;
      logic        ld;
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_rv;
   } vec_t;

   vec_t       vecs[11];
   logic [7:0] burst[6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      vecs[0]  = '{1'b1, 1'b0, 1'b1, STA,           1'b1, ST_IDLE};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, TXA,           1'b0, ST_IDLE};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, STA,           1'b0, ST_IDLE};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, STA,           1'b1, ST_IDLE};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, TXA,           1'b1, ST_IDLE};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, STA,           1'b0, ST_IDLE};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_0005, 1'b0, ST_IDLE};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, TXA + 32'd8,   1'b0, ST_IDLE};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, ST_IDLE};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, STA,           1'b1, ST_IDLE};
      vecs[10] = '{1'b1, 1'b0, 1'b0, STA,           1'b1, ST_IDLE};
      burst    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      bus.is_data_stage = 1'b0;
      bus.store_en      = 1'b0;
      bus.load_en       = 1'b0;
      bus.long_addr     = '0;
      bus.write_value   = '0;

      repeat (2) @(negedge clock);
      check("rst_tx",   32'(bus.tx),   32'h1);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_hit",  32'(bus.hit),  32'h0);
      check("rst_rv",   bus.read_value, 32'h0);
      #2 reset = 1'b0;
      @(negedge clock);

      // Decode table: nothing here may push a byte, so the line must stay idle.
      for (int i = 0; i < 11; i++) begin
         bus_op(vecs[i].ds, vecs[i].st, vecs[i].ld, vecs[i].addr, 32'h0000_0099);
         check($sformatf("vec%0d_hit", i), 32'(bus.hit), 32'(vecs[i].exp_hit));
         check($sformatf("vec%0d_rv", i),  bus.read_value, vecs[i].exp_rv);
      end
      repeat (4) @(negedge clock);
      check("decode_tx_idle",   32'(bus.tx),   32'h1);
      check("decode_busy_idle", 32'(bus.busy), 32'h0);

      // Single frame: latency and length.
      exp_q.push_back(8'h55);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_0155);
      check("lat_pre_fall", 32'(bus.tx), 32'h1);
      @(negedge clock);
      check("lat_fall", 32'(bus.tx), 32'h0);
      wait_idle(200, cyc);
      check("frame_len", 32'(cyc), 32'(FRAME_CYC));
      check("single_drained", 32'(exp_q.size()), 32'h0);

      // Back-to-back frames without an idle gap.
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_0041);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_0042);
      check("b2b_fall", 32'(bus.tx), 32'h0);
      wait_idle(400, cyc);
      check("b2b_len", 32'(cyc), 32'(2 * FRAME_CYC));
      check("b2b_drained", 32'(exp_q.size()), 32'h0);

      // Overflow: one in the shifter, four queued, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_q.push_back(burst[i]);
         bus_op(1'b1, 1'b1, 1'b0, TXA, {24'h0, burst[i]});
      end
      bus_op(1'b1, 1'b0, 1'b1, STA, 32'h0);
      check("ovf_hit", 32'(bus.hit), 32'h1);
      check("ovf_rv",  bus.read_value, 32'hD | PAR_FLAG);
      bus_op(1'b1, 1'b0, 1'b1, STA, 32'h0);
      check("ovf_clear_rv", bus.read_value, 32'h5 | PAR_FLAG);
      bus_op(1'b1, 1'b0, 1'b1, TXA, 32'h0);
      check("ovf_other_hit", 32'(bus.hit), 32'h0);
      check("ovf_other_rv",  bus.read_value, 32'h5 | PAR_FLAG);
      wait_idle(1000, cyc);
      check("ovf_drained", 32'(exp_q.size()), 32'h0);
      bus_op(1'b1, 1'b0, 1'b1, STA, 32'h0);
      check("ovf_after_rv", bus.read_value, ST_IDLE);

      // Reset mid-frame.
      exp_q.push_back(8'hA5);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_00A5);
      repeat (10) @(negedge clock);
      check("midrst_pre_tx", 32'(bus.tx), 32'h0);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_tx",   32'(bus.tx),   32'h1);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      bus_op(1'b1, 1'b0, 1'b1, STA, 32'h0);
      check("midrst_status", bus.read_value, ST_IDLE);
      exp_q.push_back(8'h3C);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_003C);
      @(negedge clock);
      wait_idle(200, cyc);
      check("midrst_len", 32'(cyc), 32'(FRAME_CYC));
      check("midrst_drained", 32'(exp_q.size()), 32'h0);

`ifdef UART_PARITY_EN
      exp_q.push_back(8'h07);
      bus_op(1'b1, 1'b1, 1'b0, TXA, 32'h0000_0007);
      @(negedge clock);
      wait_idle(200, cyc);
      check("par_len", 32'(cyc), 32'd44);
      check("par_drained", 32'(exp_q.size()), 32'h0);
`endif

      repeat (4) @(negedge clock);
      check("end_tx", 32'(bus.tx), 32'h1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
